// File: rtl/fb_pkg.sv
// Shared frame-buffer geometry and clear-FSM encoding, also used by the VGA scanner
// and the pattern generator.
package fb_pkg;

  localparam int FB_NUM_BANKS  = 15;
  localparam int FB_BANK_WIDTH = 4;
  localparam int FB_DEPTH      = 5120;
  localparam int FB_ADDR_WIDTH = 13;
  localparam int FB_DATA_WIDTH = 12;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } fb_state_t;

endpackage

// File: rtl/banked_frame_buffer_if.sv
// Write, read and clear ports of the banked frame buffer.
// The generator/scanner side uses master; the buffer uses slave.
interface banked_frame_buffer_if
  import fb_pkg::*;
#(
  parameter int BANK_WIDTH = FB_BANK_WIDTH,
  parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
  parameter int DATA_WIDTH = FB_DATA_WIDTH
);

  logic                  i_wr_valid;
  logic                  o_wr_ready;
  logic [BANK_WIDTH-1:0] i_wr_bank;
  logic [ADDR_WIDTH-1:0] i_wr_addr;
  logic [DATA_WIDTH-1:0] i_wr_data;
  logic                  o_wr_err;

  logic                  i_rd_en;
  logic [BANK_WIDTH-1:0] i_rd_bank;
  logic [ADDR_WIDTH-1:0] i_rd_addr;
  logic [DATA_WIDTH-1:0] o_rd_data;
  logic                  o_rd_valid;

  logic                  i_clear;
  logic [DATA_WIDTH-1:0] i_fill;
  logic                  o_busy;

  modport master (
    output i_wr_valid, i_wr_bank, i_wr_addr, i_wr_data,
    output i_rd_en, i_rd_bank, i_rd_addr,
    output i_clear, i_fill,
    input  o_wr_ready, o_wr_err, o_rd_data, o_rd_valid, o_busy
  );

  modport slave (
    input  i_wr_valid, i_wr_bank, i_wr_addr, i_wr_data,
    input  i_rd_en, i_rd_bank, i_rd_addr,
    input  i_clear, i_fill,
    output o_wr_ready, o_wr_err, o_rd_data, o_rd_valid, o_busy
  );

endinterface

// File: rtl/fb_bank.sv
// One frame-buffer bank: simple dual-port RAM, port A writes, port B reads through
// a registered read-first output so it maps onto a block RAM.
module fb_bank #(
  parameter int DEPTH      = 5120,
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Both updates are non-blocking, so a colliding read sees the old word.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/banked_frame_buffer.sv
// Line-banked VGA frame store: write decode with range check, clear/fill engine,
// and a two-stage read pipeline (bank read, then registered bank mux).
module banked_frame_buffer
  import fb_pkg::*;
#(
  parameter int NUM_BANKS      = FB_NUM_BANKS,
  parameter int BANK_WIDTH     = FB_BANK_WIDTH,
  parameter int DEPTH          = FB_DEPTH,
  parameter int ADDR_WIDTH     = FB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = FB_DATA_WIDTH,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic                  clk,
  input logic                  reset,
  banked_frame_buffer_if.slave bus
);

  localparam logic [BANK_WIDTH:0]   LP_NUM_BANKS = (BANK_WIDTH + 1)'(NUM_BANKS);
  localparam logic [ADDR_WIDTH:0]   LP_DEPTH     = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LP_LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  fb_state_t             r_state;
  logic [ADDR_WIDTH-1:0] r_clr_addr;
  logic [DATA_WIDTH-1:0] r_fill;
  logic                  r_init;
  logic                  r_busy;
  logic                  r_wr_ready;
  logic                  r_wr_err;

  logic                  r_rd_en_d1;
  logic                  r_rd_oob_d1;
  logic [BANK_WIDTH-1:0] r_rd_bank_d1;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;

  logic                  w_clearing;
  logic                  w_wr_fire;
  logic                  w_wr_in_range;
  logic                  w_rd_in_range;
  logic [ADDR_WIDTH-1:0] w_ram_addr;
  logic [DATA_WIDTH-1:0] w_ram_wdata;
  logic [NUM_BANKS-1:0]  w_ram_we;
  logic [DATA_WIDTH-1:0] w_bank_rdata [NUM_BANKS];
  logic [DATA_WIDTH-1:0] w_rd_mux;

  assign w_clearing    = (r_state == ST_CLEAR);
  assign w_wr_fire     = bus.i_wr_valid & r_wr_ready;
  assign w_wr_in_range = ({1'b0, bus.i_wr_bank} < LP_NUM_BANKS) &&
                         ({1'b0, bus.i_wr_addr} < LP_DEPTH);
  assign w_rd_in_range = ({1'b0, bus.i_rd_bank} < LP_NUM_BANKS) &&
                         ({1'b0, bus.i_rd_addr} < LP_DEPTH);

  // The clear engine owns port A of every bank while it runs; ready is low then.
  assign w_ram_addr  = w_clearing ? r_clr_addr : bus.i_wr_addr;
  assign w_ram_wdata = w_clearing ? r_fill     : bus.i_wr_data;

  generate
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      localparam logic [BANK_WIDTH-1:0] LP_IDX = BANK_WIDTH'(gi);

      assign w_ram_we[gi] = w_clearing |
                            (w_wr_fire & w_wr_in_range & (bus.i_wr_bank == LP_IDX));

      fb_bank #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
      ) u_bank (
        .clk     (clk),
        .i_we    (w_ram_we[gi]),
        .i_waddr (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .i_re    (bus.i_rd_en),
        .i_raddr (bus.i_rd_addr),
        .o_rdata (w_bank_rdata[gi])
      );
    end
  endgenerate

  // r_init requests the automatic post-reset clear on the first cycle out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_clr_addr <= '0;
      r_fill     <= '0;
      r_init     <= (CLEAR_ON_RESET != 0);
      r_busy     <= 1'b0;
      r_wr_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_init || bus.i_clear) begin
            r_state    <= ST_CLEAR;
            r_fill     <= bus.i_fill;
            r_clr_addr <= '0;
            r_init     <= 1'b0;
            r_busy     <= 1'b1;
            r_wr_ready <= 1'b0;
          end else begin
            r_wr_ready <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (r_clr_addr == LP_LAST_ADDR) begin
            r_state    <= ST_IDLE;
            r_clr_addr <= '0;
            r_busy     <= 1'b0;
            r_wr_ready <= 1'b1;
          end else begin
            r_clr_addr <= r_clr_addr + ADDR_WIDTH'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    w_rd_mux = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (r_rd_bank_d1 == BANK_WIDTH'(b)) begin
        w_rd_mux = w_bank_rdata[b];
      end
    end
  end

  // Bank select and range flag travel alongside the RAM read so the mux stays aligned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_en_d1   <= 1'b0;
      r_rd_oob_d1  <= 1'b0;
      r_rd_bank_d1 <= '0;
      r_rd_data    <= '0;
      r_rd_valid   <= 1'b0;
      r_wr_err     <= 1'b0;
    end else begin
      r_rd_en_d1 <= bus.i_rd_en;
      if (bus.i_rd_en) begin
        r_rd_bank_d1 <= bus.i_rd_bank;
        r_rd_oob_d1  <= ~w_rd_in_range;
      end
      r_rd_valid <= r_rd_en_d1;
      if (r_rd_en_d1) begin
        r_rd_data <= r_rd_oob_d1 ? '0 : w_rd_mux;
      end
      r_wr_err <= w_wr_fire & ~w_wr_in_range;
    end
  end

  assign bus.o_wr_ready = r_wr_ready;
  assign bus.o_wr_err   = r_wr_err;
  assign bus.o_rd_data  = r_rd_data;
  assign bus.o_rd_valid = r_rd_valid;
  assign bus.o_busy     = r_busy;

endmodule

// File: tb/tb_banked_frame_buffer.sv
// Directed bench for banked_frame_buffer: clear timing, write/read, streaming reads,
// range errors, read-first collision and reset during a clear.
module tb_banked_frame_buffer;
  import fb_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   busy_cnt;
  int   rdy_cnt;

  always #5 clk = ~clk;

  banked_frame_buffer_if bus ();

  banked_frame_buffer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %-20s got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %-20s value=0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int bank, input int addr, input logic [11:0] data);
    bus.i_wr_valid = 1'b1;
    bus.i_wr_bank  = FB_BANK_WIDTH'(bank);
    bus.i_wr_addr  = FB_ADDR_WIDTH'(addr);
    bus.i_wr_data  = data;
    tick();
    bus.i_wr_valid = 1'b0;
  endtask

  // One read: valid must still be low after the first edge, data arrives after the second.
  task automatic do_read(input string tag, input int bank, input int addr, input logic [11:0] exp);
    bus.i_rd_en   = 1'b1;
    bus.i_rd_bank = FB_BANK_WIDTH'(bank);
    bus.i_rd_addr = FB_ADDR_WIDTH'(addr);
    tick();
    bus.i_rd_en = 1'b0;
    check({tag, "_lat"}, {31'd0, bus.o_rd_valid}, 32'd0);
    tick();
    check(tag, {19'd0, bus.o_rd_valid, bus.o_rd_data}, {19'd0, 1'b1, exp});
  endtask

  // Counts busy cycles (and ready-high cycles among them); optionally pulses i_clear
  // with a different fill value at busy cycle clr_at.
  task automatic measure_busy(input int clr_at, output int b_cnt, output int r_cnt);
    logic [11:0] saved;
    saved = bus.i_fill;
    b_cnt = 0;
    r_cnt = 0;
    for (int i = 0; i < 6000; i++) begin
      tick();
      if (bus.o_busy) begin
        b_cnt++;
        if (bus.o_wr_ready) r_cnt++;
      end else if (b_cnt > 0) begin
        break;
      end
      if (clr_at > 0 && b_cnt == clr_at) begin
        bus.i_clear = 1'b1;
        bus.i_fill  = 12'h777;
      end else begin
        bus.i_clear = 1'b0;
        bus.i_fill  = saved;
      end
    end
    bus.i_clear = 1'b0;
    bus.i_fill  = saved;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.i_wr_valid = 1'b0;
    bus.i_wr_bank  = '0;
    bus.i_wr_addr  = '0;
    bus.i_wr_data  = '0;
    bus.i_rd_en    = 1'b0;
    bus.i_rd_bank  = '0;
    bus.i_rd_addr  = '0;
    bus.i_clear    = 1'b0;
    bus.i_fill     = 12'hF00;

    // Reset values and the automatic post-reset clear
    repeat (3) tick();
    check("rst_busy",     {31'd0, bus.o_busy},     32'd0);
    check("rst_wr_ready", {31'd0, bus.o_wr_ready}, 32'd0);
    check("rst_wr_err",   {31'd0, bus.o_wr_err},   32'd0);
    check("rst_rd_valid", {31'd0, bus.o_rd_valid}, 32'd0);
    check("rst_rd_data",  {20'd0, bus.o_rd_data},  32'd0);
    reset = 1'b0;
    measure_busy(0, busy_cnt, rdy_cnt);
    check("t1_busy_cycles",  busy_cnt, 32'd5120);
    check("t1_ready_in_clr", rdy_cnt,  32'd0);
    check("t1_ready_after",  {31'd0, bus.o_wr_ready}, 32'd1);
    do_read("t1_b0_a0",     0,  0,    12'hF00);
    do_read("t1_b14_a5119", 14, 5119, 12'hF00);
    do_read("t1_b7_a2560",  7,  2560, 12'hF00);

    // Simple write then read, neighbour bank untouched, output hold
    check("t2_wr_ready", {31'd0, bus.o_wr_ready}, 32'd1);
    do_write(3, 100, 12'hABC);
    check("t2_no_err", {31'd0, bus.o_wr_err}, 32'd0);
    do_read("t2_b3_a100", 3, 100, 12'hABC);
    tick();
    check("t2_hold", {19'd0, bus.o_rd_valid, bus.o_rd_data}, {19'd0, 1'b0, 12'hABC});
    do_read("t2_b4_a100", 4, 100, 12'hF00);

    // Back-to-back reads alternating banks 0 and 14
    do_write(0,  50, 12'h111);
    do_write(14, 50, 12'hEEE);
    for (int i = 0; i < 22; i++) begin
      if (i < 20) begin
        bus.i_rd_en   = 1'b1;
        bus.i_rd_bank = (i % 2 == 1) ? 4'd14 : 4'd0;
        bus.i_rd_addr = 13'd50;
      end else begin
        bus.i_rd_en = 1'b0;
      end
      tick();
      if (i >= 1 && i <= 20) begin
        check($sformatf("t3_stream_%0d", i - 1),
              {19'd0, bus.o_rd_valid, bus.o_rd_data},
              {19'd0, 1'b1, ((i - 1) % 2 == 1) ? 12'hEEE : 12'h111});
      end
    end
    bus.i_rd_en = 1'b0;

    // Out-of-range writes and reads
    do_write(15, 100, 12'h123);
    check("t4_err_bank", {31'd0, bus.o_wr_err}, 32'd1);
    tick();
    check("t4_err_bank_end", {31'd0, bus.o_wr_err}, 32'd0);
    do_write(3, 5120, 12'h456);
    check("t4_err_addr", {31'd0, bus.o_wr_err}, 32'd1);
    tick();
    check("t4_err_addr_end", {31'd0, bus.o_wr_err}, 32'd0);
    do_read("t4_b3_a100_kept", 3, 100, 12'hABC);
    do_read("t4_b3_a0_kept",   3, 0,   12'hF00);
    do_read("t4_b14_a100",     14, 100, 12'hF00);
    do_read("t4_rd_bank15",    15, 100, 12'h000);

    // Same-cycle read and write: read-first
    do_write(2, 7, 12'h010);
    bus.i_wr_valid = 1'b1;
    bus.i_wr_bank  = 4'd2;
    bus.i_wr_addr  = 13'd7;
    bus.i_wr_data  = 12'h020;
    bus.i_rd_en    = 1'b1;
    bus.i_rd_bank  = 4'd2;
    bus.i_rd_addr  = 13'd7;
    tick();
    bus.i_wr_valid = 1'b0;
    bus.i_rd_en    = 1'b0;
    tick();
    check("t5_read_first", {19'd0, bus.o_rd_valid, bus.o_rd_data}, {19'd0, 1'b1, 12'h010});
    do_read("t5_read_new", 2, 7, 12'h020);

    // Manual clear, reads during it, reset mid-clear with a read in flight
    bus.i_fill  = 12'h0A5;
    bus.i_clear = 1'b1;
    tick();
    bus.i_clear = 1'b0;
    check("t6_busy_start", {31'd0, bus.o_busy}, 32'd1);
    do_read("t6_rd_uncleared", 1, 4000, 12'hF00);
    do_read("t6_rd_cleared",   1, 0,    12'h0A5);
    repeat (990) tick();
    bus.i_rd_en   = 1'b1;
    bus.i_rd_bank = 4'd1;
    bus.i_rd_addr = 13'd0;
    tick();
    bus.i_rd_en = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t6_in_reset_%0d", i),
            {16'd0, bus.o_busy, bus.o_wr_ready, bus.o_wr_err, bus.o_rd_valid, bus.o_rd_data},
            32'd0);
    end
    bus.i_fill = 12'h5A5;
    reset = 1'b0;
    measure_busy(2000, busy_cnt, rdy_cnt);
    check("t6_busy_cycles",  busy_cnt, 32'd5120);
    check("t6_ready_in_clr", rdy_cnt,  32'd0);
    do_read("t6_b0_a0",     0, 0,    12'h5A5);
    do_read("t6_b9_a5119",  9, 5119, 12'h5A5);
    do_read("t6_b2_a7",     2, 7,    12'h5A5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
